// File: rtl/sample_pkg.sv
// Shared sample format and helpers for the block-average stage.
// Samples are sfix17_En16 (signed, 16 fractional bits).
package sample_pkg;

    localparam int SAMPLE_W    = 17;
    localparam int SAMPLE_FRAC = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Half an LSB of the mean, expressed in units of the raw sum.
    function automatic int round_bias(input int log2n);
        return 1 << (log2n - 1);
    endfunction

endpackage

// File: rtl/avg_out_fifo.sv
// Two-entry output FIFO for block means; push/pop/flush.
// Ports: clk, reset, i_push, i_pop, i_flush, i_data -> o_data (head, 0 when
// empty), o_full, o_empty, o_count.
module avg_out_fifo #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty,
    output logic [1:0]   o_count
);

    logic [1:0]   r_cnt;
    logic [W-1:0] r_e0;
    logic [W-1:0] r_e1;
    logic         w_pop;
    logic         w_push;

    assign o_count = r_cnt;
    assign o_full  = (r_cnt == 2'd2);
    assign o_empty = (r_cnt == 2'd0);
    assign o_data  = o_empty ? '0 : r_e0;

    // A pop frees a slot in the same cycle, so a full FIFO still
    // accepts a push when it is also being popped.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_cnt <= 2'd0;
        end else if (w_push && w_pop) begin
            if (o_full) begin
                r_e0 <= r_e1;
                r_e1 <= i_data;
            end else begin
                r_e0 <= i_data;
            end
        end else if (w_push) begin
            if (o_empty) r_e0 <= i_data;
            else         r_e1 <= i_data;
            r_cnt <= r_cnt + 2'd1;
        end else if (w_pop) begin
            r_e0  <= r_e1;
            r_cnt <= r_cnt - 2'd1;
        end
    end

endmodule

// File: rtl/sample_block_avg.sv
// Decimating block average: sums 2^LOG2_N samples, emits the rounded mean
// through a 2-entry valid/ready buffer; never stalls upstream, drops when full.
// Ports: clk, reset (sync, active-high), in_valid, in_data, clear,
// out_valid, out_ready, out_data, overflow, drop_cnt.
// Macro SAMPLE_BLOCK_AVG_MINMAX_EN adds out_min/out_max per-block extremes.
module sample_block_avg
    import sample_pkg::*;
#(
    parameter int LOG2_N = 4,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [16:0]       in_data,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [16:0]       out_data,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt
`ifdef SAMPLE_BLOCK_AVG_MINMAX_EN
    ,
    output logic [16:0]       out_min,
    output logic [16:0]       out_max
`endif
);

    localparam int AW = SAMPLE_W + LOG2_N + 1;
    localparam logic signed [AW-1:0] BIAS = AW'(round_bias(LOG2_N));
`ifdef SAMPLE_BLOCK_AVG_MINMAX_EN
    localparam int FW = 3 * SAMPLE_W;
`else
    localparam int FW = SAMPLE_W;
`endif

    logic signed [AW-1:0] r_acc;
    logic signed [AW-1:0] r_sum;
    logic [LOG2_N-1:0]    r_cnt;
    logic                 r_done;
    logic                 r_ovf;
    logic [DROP_W-1:0]    r_drop;

    sample_t              w_smp;
    logic signed [AW-1:0] w_in_ext;
    logic signed [AW-1:0] w_rounded;
    logic [SAMPLE_W-1:0]  w_mean;
    logic                 w_last;
    logic                 w_pop;
    logic                 w_drop;
    logic                 w_full;
    logic                 w_empty;
    logic [1:0]           w_fifo_cnt;
    logic [FW-1:0]        w_push_data;
    logic [FW-1:0]        w_head;
    logic                 w_unused;

    assign w_smp    = in_data;
    assign w_in_ext = AW'(w_smp);
    assign w_last   = &r_cnt;

    // Arithmetic shift of the biased sum; the guard bit in the accumulator
    // keeps the result inside 17 bits, so the low slice is the mean.
    assign w_rounded = r_sum + BIAS;
    assign w_mean    = w_rounded[LOG2_N +: SAMPLE_W];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_acc  <= '0;
            r_sum  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (in_valid) begin
                if (w_last) begin
                    r_sum  <= r_acc + w_in_ext;
                    r_acc  <= '0;
                    r_done <= 1'b1;
                end else begin
                    r_acc <= r_acc + w_in_ext;
                end
                r_cnt <= r_cnt + LOG2_N'(1);
            end
        end
    end

`ifdef SAMPLE_BLOCK_AVG_MINMAX_EN
    sample_t r_min;
    sample_t r_max;
    sample_t r_bmin;
    sample_t r_bmax;
    sample_t w_lo;
    sample_t w_hi;

    // The first sample of a block seeds both extremes.
    assign w_lo = (r_cnt == '0 || w_smp < r_min) ? w_smp : r_min;
    assign w_hi = (r_cnt == '0 || w_smp > r_max) ? w_smp : r_max;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_min  <= '0;
            r_max  <= '0;
            r_bmin <= '0;
            r_bmax <= '0;
        end else if (in_valid) begin
            r_min <= w_lo;
            r_max <= w_hi;
            if (w_last) begin
                r_bmin <= w_lo;
                r_bmax <= w_hi;
            end
        end
    end

    assign w_push_data = {w_mean, r_bmin, r_bmax};
    assign out_min     = w_head[2*SAMPLE_W-1 -: SAMPLE_W];
    assign out_max     = w_head[SAMPLE_W-1:0];
`else
    assign w_push_data = w_mean;
`endif

    assign out_valid = ~w_empty;
    assign out_data  = w_head[FW-1 -: SAMPLE_W];
    assign w_pop     = out_valid & out_ready;
    assign w_drop    = r_done & w_full & ~w_pop & ~clear;

    avg_out_fifo #(
        .W (FW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_done),
        .i_pop   (w_pop),
        .i_flush (clear),
        .i_data  (w_push_data),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_fifo_cnt)
    );

    // Drop statistics survive clear; only reset wipes them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf  <= 1'b0;
            r_drop <= '0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (~&r_drop) r_drop <= r_drop + DROP_W'(1);
        end
    end

    assign overflow = r_ovf;
    assign drop_cnt = r_drop;

    assign w_unused = ^{w_rounded[LOG2_N-1:0], w_rounded[AW-1], w_fifo_cnt};

endmodule

// File: tb/tb_sample_block_avg.sv
// Self-checking bench for sample_block_avg: queue-based reference model
// compared every cycle, plus directed literal expectations.
module tb_sample_block_avg;

    localparam int LOG2_N = 4;
    localparam int N      = 1 << LOG2_N;
    localparam int DROP_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [16:0]       in_data = '0;
    logic              clear = 1'b0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [16:0]       out_data;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;
`ifdef SAMPLE_BLOCK_AVG_MINMAX_EN
    logic [16:0]       out_min;
    logic [16:0]       out_max;
`endif

    sample_block_avg #(
        .LOG2_N (LOG2_N),
        .DROP_W (DROP_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
`ifdef SAMPLE_BLOCK_AVG_MINMAX_EN
        ,
        .out_min   (out_min),
        .out_max   (out_max)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit armed    = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: samples of the open block, one result in flight,
    // and the output buffer as queues.
    int          blk[$];
    bit          pend_v = 1'b0;
    logic [16:0] pend_m, pend_mn, pend_mx;
    logic [16:0] qm[$], qmn[$], qmx[$];
    bit          m_ovf = 1'b0;
    int          m_drops = 0;

    logic [16:0] got[$], got_mn[$], got_mx[$];

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                blk.delete(); pend_v = 0;
                qm.delete(); qmn.delete(); qmx.delete();
                m_ovf = 0; m_drops = 0;
            end else if (clear) begin
                blk.delete(); pend_v = 0;
                qm.delete(); qmn.delete(); qmx.delete();
            end else begin
                bit          pop;
                bit          npv;
                logic [16:0] nm, nmn, nmx;
                pop = (qm.size() > 0) && out_ready;
                npv = 0;
                nm = '0; nmn = '0; nmx = '0;
                if (in_valid) begin
                    blk.push_back(int'($signed(in_data)));
                    if (blk.size() == N) begin
                        int s, lo, hi, num, q;
                        s = 0; lo = blk[0]; hi = blk[0];
                        foreach (blk[i]) begin
                            s += blk[i];
                            if (blk[i] < lo) lo = blk[i];
                            if (blk[i] > hi) hi = blk[i];
                        end
                        num = s + N / 2;
                        q = (num >= 0) ? num / N : -((-num + N - 1) / N);
                        nm = q[16:0]; nmn = lo[16:0]; nmx = hi[16:0];
                        npv = 1;
                        blk.delete();
                    end
                end
                if (pop) begin
                    void'(qm.pop_front());
                    void'(qmn.pop_front());
                    void'(qmx.pop_front());
                end
                if (pend_v) begin
                    if (qm.size() < 2) begin
                        qm.push_back(pend_m);
                        qmn.push_back(pend_mn);
                        qmx.push_back(pend_mx);
                    end else begin
                        m_ovf = 1;
                        if (m_drops < (1 << DROP_W) - 1) m_drops++;
                    end
                end
                pend_v = npv; pend_m = nm; pend_mn = nmn; pend_mx = nmx;
            end
        end
    end

    // Per-cycle compare against the model, and a log of accepted outputs.
    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                chk("m_valid", out_valid, (qm.size() > 0) ? 1 : 0);
                chk("m_data", out_data, (qm.size() > 0) ? qm[0] : 17'h0);
                chk("m_ovf", overflow, m_ovf);
                chk("m_drop", drop_cnt, m_drops);
`ifdef SAMPLE_BLOCK_AVG_MINMAX_EN
                chk("m_min", out_min, (qm.size() > 0) ? qmn[0] : 17'h0);
                chk("m_max", out_max, (qm.size() > 0) ? qmx[0] : 17'h0);
`endif
                if (out_valid && out_ready) begin
                    got.push_back(out_data);
`ifdef SAMPLE_BLOCK_AVG_MINMAX_EN
                    got_mn.push_back(out_min);
                    got_mx.push_back(out_max);
`endif
                end
            end
        end
    end

    function automatic logic [31:0] got_at(input int i);
        return (i < got.size()) ? {15'h0, got[i]} : 32'hDEAD_BEEF;
    endfunction

    task automatic step(input logic v, input logic [16:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic blk15(input logic [16:0] a, input logic [16:0] b);
        for (int i = 0; i < N - 1; i++) step(1'b1, a);
        step(1'b1, b);
        in_valid = 1'b0;
    endtask

    int base;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        armed = 1'b1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", drop_cnt, 0);

        // Basic mean and two-edge latency.
        out_ready = 1'b1;
        base = got.size();
        blk15(17'h08000, 17'h08000);
        chk("lat_k", out_valid, 0);
        idle(1);
        chk("lat_k1", out_valid, 1);
        chk("lat_data", out_data, 17'h08000);
        idle(3);
        chk("one_pulse", got.size(), base + 1);
        chk("mean_half", got_at(base), 17'h08000);

        // Rounding and range corners.
        base = got.size();
        blk15(17'h0, 17'h00008);      idle(4);
        blk15(17'h0, 17'h1FFF8);      idle(4);
        blk15(17'h0FFFF, 17'h0FFFF);  idle(4);
        blk15(17'h10000, 17'h10000);  idle(4);
        chk("rnd_up", got_at(base), 17'h00001);
        chk("rnd_neg", got_at(base + 1), 17'h00000);
        chk("max_pos", got_at(base + 2), 17'h0FFFF);
        chk("max_neg", got_at(base + 3), 17'h10000);

        // Three blocks with the consumer stalled: third is dropped.
        out_ready = 1'b0;
        blk15(17'h1, 17'h1);
        blk15(17'h2, 17'h2);
        blk15(17'h3, 17'h3);
        idle(4);
        chk("ovf_set", overflow, 1);
        chk("drop_one", drop_cnt, 1);
        chk("held_head", out_data, 17'h1);
        base = got.size();
        out_ready = 1'b1;
        idle(4);
        chk("pop1", got_at(base), 17'h1);
        chk("pop2", got_at(base + 1), 17'h2);
        chk("pop_cnt", got.size(), base + 2);

        // Full buffer, new block arrives on a popping cycle: no drop.
        out_ready = 1'b0;
        blk15(17'h2, 17'h2);
        blk15(17'h3, 17'h3);
        idle(3);
        base = got.size();
        blk15(17'h4, 17'h4);
        out_ready = 1'b1;
        idle(5);
        chk("fp_pop2", got_at(base), 17'h2);
        chk("fp_pop3", got_at(base + 1), 17'h3);
        chk("fp_pop4", got_at(base + 2), 17'h4);
        chk("fp_drop", drop_cnt, 1);

        // Reset mid-block discards the partial sum.
        for (int i = 0; i < 7; i++) step(1'b1, 17'h00100);
        in_valid = 1'b0;
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("rst2_drop", drop_cnt, 0);
        base = got.size();
        blk15(17'h1, 17'h1);
        idle(4);
        chk("rst_mid", got_at(base), 17'h1);

        // Create one drop, then clear mid-block with a sample on the
        // clear cycle; drop statistics must survive.
        out_ready = 1'b0;
        blk15(17'h1, 17'h1);
        blk15(17'h1, 17'h1);
        blk15(17'h1, 17'h1);
        idle(3);
        chk("pre_clr_drop", drop_cnt, 1);
        for (int i = 0; i < 7; i++) step(1'b1, 17'h00100);
        clear = 1'b1;
        step(1'b1, 17'h00100);
        clear = 1'b0;
        in_valid = 1'b0;
        chk("clr_empty", out_valid, 0);
        chk("clr_ovf", overflow, 1);
        out_ready = 1'b1;
        base = got.size();
        blk15(17'h1, 17'h1);
        idle(4);
        chk("clr_mid", got_at(base), 17'h1);
        chk("clr_cnt", got.size(), base + 1);
        chk("clr_drop", drop_cnt, 1);

`ifdef SAMPLE_BLOCK_AVG_MINMAX_EN
        base = got.size();
        step(1'b1, 17'h00005);
        step(1'b1, 17'h1FFFD);
        step(1'b1, 17'h0FFFF);
        step(1'b1, 17'h10000);
        for (int i = 0; i < 12; i++) step(1'b1, 17'h0);
        in_valid = 1'b0;
        idle(4);
        chk("mm_data", got_at(base), 17'h0);
        chk("mm_min", (base < got_mn.size()) ? got_mn[base] : 17'h1ABCD,
            17'h10000);
        chk("mm_max", (base < got_mx.size()) ? got_mx[base] : 17'h1ABCD,
            17'h0FFFF);
        chk("mm_idle_min", out_min, 17'h0);
`endif

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sample_block_avg.md
Name: sample_block_avg

Overview:
- Decimating block-average stage directly downstream of the fixed-point polynomial pipeline.
- Consumes its sfix17_En16 output stream, one sample per qualified cycle.
- Accumulates blocks of 2^LOG2_N samples and emits the rounded mean through a valid/ready port backed by a 2-entry output buffer.
- The upstream pipeline cannot stall, so this block never back-pressures it. Results that cannot be buffered are dropped and counted.

Parameters:
- LOG2_N, 4, log2 of block length N; legal range 1..8.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data qualifier; no ready returned upstream.
- in_data  in  17  sample, sfix17_En16.
- clear  in  1  synchronous flush: discards the partial block and empties the output buffer.
- out_valid  out  1  out_data holds a mean.
- out_ready  in  1  consumer accepts out_data when out_valid is high.
- out_data  out  17  block mean, sfix17_En16.
- overflow  out  1  sticky; set on the first dropped result.
- drop_cnt  out  DROP_W  count of dropped results, saturating.

Behaviour:
- Reset: acc=0, cnt=0, done=0, buffer empty. Outputs: out_valid=0, out_data=0, overflow=0, drop_cnt=0. Reset in mid-block discards partial sums.
- Accumulator: signed, 17+LOG2_N+1 bits. cnt is LOG2_N bits and wraps.
- On each accepted sample (in_valid=1):
  - If cnt==N-1: the registered block sum takes acc+in_data, acc is reset to 0, and done=1.
  - Otherwise: acc accumulates in_data and cnt increments.
  - done is a 1-cycle pulse.
- Mean computation: mean = (sum + 2^(LOG2_N-1)) >>> LOG2_N, arithmetic shift (round half up). The result always fits 17 bits; mean of all 0x0FFFF is 0x0FFFF, mean of all 0x10000 is 0x10000.
- Latency: Nth sample accepted at edge k; done registered at k; mean written to the buffer at edge k+1; out_valid visible after k+1 when the buffer was empty.
- Throughput: one block per N accepted samples.
- Output buffer: 2-entry FIFO. out_data shows the head entry and is 0 when empty. A pop happens when out_valid && out_ready.
- Write while full with no pop in the same cycle: result dropped, overflow set, drop_cnt incremented (holds at all-ones).
- Write while full with a pop in the same cycle: both take effect, occupancy stays 2, no drop.
- Write and pop when occupancy is 1: occupancy stays 1, the new value becomes head.
- clear: same cycle effect as reset on acc, cnt, done and the buffer. overflow and drop_cnt are kept. A sample presented in the same cycle as clear is discarded. clear has priority over write and pop.
- in_valid=0 cycles: state holds; gaps inside a block are allowed.

Optional Feature:
- Macro SAMPLE_BLOCK_AVG_MINMAX_EN.
- Defined: adds outputs out_min[16:0] and out_max[16:0], carrying per-block signed minimum and maximum.
  - Tracked with the sum; reset to the first sample of each block.
  - Stored in the FIFO alongside the mean and popped with it.
  - Both read 0 when the buffer is empty.
- Undefined: no min/max ports, registers or FIFO width.

Decomposition:
- Package sample_pkg:
  - SAMPLE_W=17, SAMPLE_FRAC=16.
  - typedef sample_t (signed [16:0]).
  - Rounding helper constant derivation per LOG2_N.
- Sub-module avg_out_fifo: parameterised width, depth 2, push/pop/flush, full/empty/count. Implements the simultaneous push/pop rules above.

Test Plan:
- LOG2_N=4, out_ready=1, 16 samples of 0x08000 -> one out_valid pulse 2 cycles after the 16th sample, out_data=0x08000.
- Rounding: 15 x 0 then 8 -> out_data=1. 15 x 0 then -8 (0x1FFF8) -> 0. All 0x0FFFF -> 0x0FFFF. All 0x10000 -> 0x10000.
- out_ready=0 for 3 complete blocks (means 1, 2, 3) -> first two held in order; third dropped; overflow=1, drop_cnt=1. Then out_ready=1 -> pops 1 then 2.
- Buffer full while a new block completes with out_ready=1 in that cycle -> no drop; subsequent pops yield 2, 3, 4 in order.
- 7 samples of 0x00100, then reset for 1 cycle, then 16 samples of 0x00001 -> first output is 1. Repeating the sequence with clear instead of reset gives the same result and leaves drop_cnt unchanged.
- Feature on: block {5, -3, 0x0FFFF, 0x10000, then 12 x 0} -> out_min=0x10000, out_max=0x0FFFF, out_data=0.
